alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width.
REQ-002 The block SHALL have parameter OPW, default 4, ALU opcode width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-006 The block SHALL have port req_ready  output  2  per-requester accept; at most one bit high.
REQ-007 The block SHALL have port req_a  input  2*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port req_b  input  2*WIDTH  operand B, same packing.
REQ-009 The block SHALL have port req_op  input  2*OPW  opcode, requester i in bits [i*OPW +: OPW].
REQ-010 The block SHALL have port alu_a, alu_b  output  WIDTH each  registered operands to the shared ALU.
REQ-011 The block SHALL have port alu_opcode  output  OPW  registered opcode to the ALU.
REQ-012 The block SHALL have port alu_out  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_opcode).
REQ-013 The block SHALL have port alu_zero, alu_neg, alu_ovf  input  1 each  ALU flags.
REQ-014 The block SHALL have port rsp_valid  output  1  response valid.
REQ-015 The block SHALL have port rsp_ready  input  1  response consumer ready.
REQ-016 The block SHALL have port rsp_id  output  1  requester index of the response.
REQ-017 The block SHALL have port rsp_out  output  WIDTH  captured result.
REQ-018 The block SHALL have port rsp_zero, rsp_neg, rsp_ovf  output  1 each  captured flags.

Function
REQ-019 The FSM SHALL have states IDLE, EXEC, RESP; transitions: IDLE->EXEC on accept; EXEC->RESP unconditionally; RESP->IDLE when rsp_valid&&rsp_ready.
REQ-020 In IDLE, req_ready SHALL be combinational: one-hot for the granted requester if any req_valid, else 0; req_ready SHALL be 0 in EXEC and RESP.
REQ-021 Arbitration SHALL be round-robin: both valid -> grant requester != last_grant; one valid -> grant it; last_grant updates only on accept.
REQ-022 On accept (cycle N) the granted requester's a/b/op SHALL be registered onto alu_a/alu_b/alu_opcode, visible in cycle N+1 (EXEC), held until the next accept.
REQ-023 At end of EXEC, alu_out and flags SHALL be captured into rsp_out/rsp_*; rsp_valid SHALL be high from cycle N+2.
REQ-024 rsp_valid, rsp_id, rsp_out and flags SHALL be held stable while rsp_valid&&!rsp_ready (backpressure, indefinite).
REQ-025 Minimum issue interval SHALL be 3 cycles (accept N, response handshake N+2, next accept N+3); no accept in the handshake cycle.
REQ-026 A requester dropping req_valid before acceptance SHALL lose nothing; no request is latched without req_valid&&req_ready.

Reset
REQ-027 While rst_n=0: state=IDLE, last_grant=1 (requester 0 wins first tie), alu_a/alu_b/alu_opcode=0, rsp_valid=0, rsp_id=0, rsp_out=0, all rsp flags=0, req_ready=0.
REQ-028 Reset asserted mid-EXEC or mid-RESP SHALL discard the transaction without issuing a response; deassertion resumes in IDLE.

Configuration
REQ-029 Macro ALU_ARB_STICKY_OVF_EN, when defined, SHALL add input sticky_clr (2) and output sticky_ovf (2): bit i set when a response with rsp_id=i, rsp_ovf=1 handshakes; cleared by sticky_clr[i]; set wins on a same-cycle clear; reset 0.
REQ-030 Without ALU_ARB_STICKY_OVF_EN those ports and registers SHALL be absent; all other behaviour identical.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding (IDLE=0, EXEC=1, RESP=2) and requester count constant 2.
REQ-032 Round-robin grant logic SHALL be one sub-module, rr_arb2 (inputs valid[1:0], last_grant; output one-hot grant).

Verification
REQ-033 req_valid=01, a0=7, b0=5, op0=15 at N -> req_ready=01 at N; alu_a=7, alu_b=5, alu_opcode=15 at N+1; rsp_valid=1, rsp_id=0, rsp_out=ALU-model value at N+2.
REQ-034 req_valid=11 held after reset for 4 transactions, rsp_ready=1 -> grant order 0,1,0,1; accepts 3 cycles apart.
REQ-035 Response pending with rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=00 throughout; handshake then next accept one cycle later.
REQ-036 Reset pulse during EXEC -> no rsp_valid; all outputs at reset values next cycle.
REQ-037 With ALU_ARB_STICKY_OVF_EN, requester 1 op with model alu_ovf=1 -> sticky_ovf=10 after handshake; sticky_clr=10 concurrent with another overflow response for 1 -> stays 10; lone clear -> 00.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encoding,
// requester count and a one-hot helper.
package alu_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // One-hot vector for a requester index
    function automatic logic [NUM_REQ-1:0] onehot2(input logic idx);
        logic [NUM_REQ-1:0] v;
        if (idx) begin
            v = 2'b10;
        end else begin
            v = 2'b01;
        end
        return v;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last
// time is granted; a lone requester always wins.
module rr_arb2
    import alu_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);

    // Grant selection
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters (IDLE/EXEC/RESP).
// Optional sticky overflow tracking when ALU_ARB_STICKY_OVF_EN is defined.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [2*WIDTH-1:0]     req_a,
    input  logic [2*WIDTH-1:0]     req_b,
    input  logic [2*OPW-1:0]       req_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [OPW-1:0]         alu_opcode,
    input  logic [WIDTH-1:0]       alu_out,
    input  logic                   alu_zero,
    input  logic                   alu_neg,
    input  logic                   alu_ovf,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [WIDTH-1:0]       rsp_out,
    output logic                   rsp_zero,
    output logic                   rsp_neg,
    output logic                   rsp_ovf
`ifdef ALU_ARB_STICKY_OVF_EN
    ,
    input  logic [NUM_REQ-1:0]     sticky_clr,
    output logic [NUM_REQ-1:0]     sticky_ovf
`endif
);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_last_grant;
    logic               r_cur_id;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [OPW-1:0]     r_alu_op;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_out;
    logic               r_rsp_zero;
    logic               r_rsp_neg;
    logic               r_rsp_ovf;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_req_ready;
    logic               w_accept;
    logic               w_grant_idx;
    logic               w_handshake;

    rr_arb2 u_rr_arb2 (
        .valid      (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    // Ready is offered only while idle and out of reset
    always_comb begin
        w_req_ready = 2'b00;
        if ((r_state == IDLE) && rst_n) begin
            w_req_ready = w_grant;
        end else begin
            w_req_ready = 2'b00;
        end
    end

    assign w_accept    = |(req_valid & w_req_ready);
    assign w_grant_idx = w_req_ready[1];
    assign w_handshake = r_rsp_valid && rsp_ready;

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = w_accept ? EXEC : IDLE;
            EXEC:    w_next_state = RESP;
            RESP:    w_next_state = w_handshake ? IDLE : RESP;
            default: w_next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand capture on accept, result capture at end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_cur_id     <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_out    <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_neg    <= 1'b0;
            r_rsp_ovf    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant_idx;
                r_cur_id     <= w_grant_idx;
                r_alu_a      <= w_grant_idx ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
                r_alu_b      <= w_grant_idx ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
                r_alu_op     <= w_grant_idx ? req_op[OPW +: OPW] : req_op[0 +: OPW];
            end
            if (r_state == EXEC) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_cur_id;
                r_rsp_out   <= alu_out;
                r_rsp_zero  <= alu_zero;
                r_rsp_neg   <= alu_neg;
                r_rsp_ovf   <= alu_ovf;
            end else if (w_handshake) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_STICKY_OVF_EN
    logic [NUM_REQ-1:0] r_sticky;
    logic [NUM_REQ-1:0] w_sticky_set;

    assign w_sticky_set = (w_handshake && r_rsp_ovf) ? onehot2(r_rsp_id) : 2'b00;

    // Sticky overflow: a set in the same cycle overrides a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 2'b00;
        end else begin
            r_sticky <= (r_sticky & ~sticky_clr) | w_sticky_set;
        end
    end

    assign sticky_ovf = r_sticky;
`endif

    assign req_ready  = w_req_ready;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_out    = r_rsp_out;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_neg    = r_rsp_neg;
    assign rsp_ovf    = r_rsp_ovf;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and a response
// scoreboard; sticky-overflow checks are included under ALU_ARB_STICKY_OVF_EN.
module tb_alu_arbiter;

    localparam int WIDTH = 16;
    localparam int OPW   = 4;

    typedef struct {
        logic [1:0]       valid;
        logic [WIDTH-1:0] a0;
        logic [WIDTH-1:0] b0;
        logic [OPW-1:0]   op0;
        logic [WIDTH-1:0] a1;
        logic [WIDTH-1:0] b1;
        logic [OPW-1:0]   op1;
        logic [1:0]       exp_ready;
    } vec_t;

    typedef struct {
        logic        id;
        logic [18:0] res;
    } rsp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         req_valid = 2'b00;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a = '0;
    logic [2*WIDTH-1:0] req_b = '0;
    logic [2*OPW-1:0]   req_op = '0;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [OPW-1:0]     alu_opcode;
    logic [WIDTH-1:0]   alu_out;
    logic               alu_zero;
    logic               alu_neg;
    logic               alu_ovf;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_out;
    logic               rsp_zero;
    logic               rsp_neg;
    logic               rsp_ovf;
`ifdef ALU_ARB_STICKY_OVF_EN
    logic [1:0]         sticky_clr = 2'b00;
    logic [1:0]         sticky_ovf;
`endif

    int   errors = 0;
    int   checks = 0;
    rsp_t sb_q[$];
    vec_t tbl[8];

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .alu_ovf    (alu_ovf),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_out    (rsp_out),
        .rsp_zero   (rsp_zero),
        .rsp_neg    (rsp_neg),
        .rsp_ovf    (rsp_ovf)
`ifdef ALU_ARB_STICKY_OVF_EN
        ,
        .sticky_clr (sticky_clr),
        .sticky_ovf (sticky_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {ovf, neg, zero, result}
    function automatic logic [18:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] op);
        logic [15:0] r;
        logic        v;
        v = 1'b0;
        case (op)
            4'd1: begin
                r = a - b;
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: begin
                r = a + b;
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
        endcase
        return {v, r[15], (r == 16'd0), r};
    endfunction

    logic [18:0] w_alu;
    assign w_alu    = alu_model(alu_a, alu_b, alu_opcode);
    assign alu_out  = w_alu[15:0];
    assign alu_zero = w_alu[16];
    assign alu_neg  = w_alu[17];
    assign alu_ovf  = w_alu[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rsp();
        rsp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_sb: got response id %0d expected none at %0t", rsp_id, $time);
        end else begin
            e = sb_q.pop_front();
            check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
            check("rsp_out", {16'd0, rsp_out}, {16'd0, e.res[15:0]});
            check("rsp_flags", {29'd0, rsp_ovf, rsp_neg, rsp_zero}, {29'd0, e.res[18:16]});
        end
    endtask

    task automatic drive(input vec_t v);
        req_valid = v.valid;
        req_a     = {v.a1, v.a0};
        req_b     = {v.b1, v.b0};
        req_op    = {v.op1, v.op0};
    endtask

    // Called on a negedge in IDLE; returns on the negedge of cycle N+2
    task automatic run_vec(input vec_t v);
        logic       idx;
        rsp_t       e;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [3:0]  eo;
        drive(v);
        rsp_ready = 1'b1;
        #1;
        check("req_ready_N", {30'd0, req_ready}, {30'd0, v.exp_ready});
        idx = v.exp_ready[1];
        ea  = idx ? v.a1 : v.a0;
        eb  = idx ? v.b1 : v.b0;
        eo  = idx ? v.op1 : v.op0;
        e.id  = idx;
        e.res = alu_model(ea, eb, eo);
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("alu_a", {16'd0, alu_a}, {16'd0, ea});
        check("alu_b", {16'd0, alu_b}, {16'd0, eb});
        check("alu_opcode", {28'd0, alu_opcode}, {28'd0, eo});
        check("req_ready_exec", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        #1;
        check_rsp();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {30'd0, req_ready}, 32'd0);
        check({tag, "_alu"}, {alu_opcode, alu_b, alu_a}, 32'd0);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_rsp"}, {12'd0, rsp_ovf, rsp_neg, rsp_zero, rsp_id, rsp_out}, 32'd0);
`ifdef ALU_ARB_STICKY_OVF_EN
        check({tag, "_sticky"}, {30'd0, sticky_ovf}, 32'd0);
`endif
    endtask

    initial begin
        int          ngr;
        int          gcyc[4];
        logic        gid[4];
        logic [15:0] snap_out;
        vec_t        v;

        tbl[0] = '{2'b01, 16'd7,      16'd5,      4'd15, 16'd0,      16'd0,      4'd0, 2'b01};
        tbl[1] = '{2'b11, 16'd1,      16'd2,      4'd0,  16'h7FFF,   16'd1,      4'd0, 2'b10};
        tbl[2] = '{2'b11, 16'd9,      16'd9,      4'd1,  16'd3,      16'd3,      4'd3, 2'b01};
        tbl[3] = '{2'b10, 16'd0,      16'd0,      4'd0,  16'hF0F0,   16'h0FF0,   4'd2, 2'b10};
        tbl[4] = '{2'b10, 16'd0,      16'd0,      4'd0,  16'h00FF,   16'hFF00,   4'd3, 2'b10};
        tbl[5] = '{2'b11, 16'hAAAA,   16'h5555,   4'd4,  16'd1,      16'd1,      4'd0, 2'b01};
        tbl[6] = '{2'b11, 16'd2,      16'd2,      4'd0,  16'h8000,   16'd1,      4'd1, 2'b10};
        tbl[7] = '{2'b01, 16'd0,      16'd0,      4'd0,  16'd0,      16'd0,      4'd0, 2'b01};

        // Reset values, with requests pending to show ready is held low
        req_valid = 2'b11;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b00;

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i]);
            @(negedge clk);
        end

        // Fresh reset, then both requesters held for four transactions
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        v = '{2'b11, 16'd100, 16'd1, 4'd0, 16'd50, 16'd60, 4'd1, 2'b00};
        drive(v);
        rsp_ready = 1'b1;
        ngr = 0;
        for (int c = 0; c < 13; c++) begin
            if (ngr == 4) req_valid = 2'b00;
            #1;
            if (rsp_valid) check_rsp();
            if (req_ready != 2'b00 && ngr < 4) begin
                rsp_t e;
                gcyc[ngr] = c;
                gid[ngr]  = req_ready[1];
                e.id  = req_ready[1];
                e.res = req_ready[1] ? alu_model(16'd50, 16'd60, 4'd1)
                                     : alu_model(16'd100, 16'd1, 4'd0);
                sb_q.push_back(e);
                ngr++;
            end
            @(negedge clk);
        end
        check("rr_count", ngr, 32'd4);
        for (int g = 0; g < 4; g++) begin
            check("rr_order", {31'd0, gid[g]}, g[31:0] & 32'd1);
            if (g > 0) check("rr_spacing", gcyc[g] - gcyc[g-1], 32'd3);
        end
        check("sb_empty_rr", sb_q.size(), 32'd0);

        // Backpressure: response held for five cycles, ready withheld
        v = '{2'b01, 16'h7FFF, 16'd1, 4'd0, 16'd4, 16'd4, 4'd1, 2'b01};
        drive(v);
        rsp_ready = 1'b0;
        #1;
        check("bp_ready_N", {30'd0, req_ready}, 32'd1);
        sb_q.push_back('{1'b0, alu_model(16'h7FFF, 16'd1, 4'd0)});
        @(negedge clk);
        req_valid = 2'b11;
        @(negedge clk);
        #1;
        check_rsp();
        snap_out = alu_model(16'h7FFF, 16'd1, 4'd0) & 19'h0FFFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_hold", {12'd0, rsp_ovf, rsp_neg, rsp_zero, rsp_id, rsp_out},
                  {12'd0, 3'b110, 1'b0, snap_out});
            check("bp_ready", {30'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_after_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_after_ready", {30'd0, req_ready}, 32'd2);
        req_valid = 2'b00;
        @(negedge clk);

        // Reset pulse during EXEC discards the transaction
        v = '{2'b01, 16'd3, 16'd4, 4'd0, 16'd0, 16'd0, 4'd0, 2'b01};
        drive(v);
        #1;
        check("rst_ready_N", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        req_valid = 2'b11;
        #1;
        check("midrst_first_tie", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;
        @(negedge clk);

`ifdef ALU_ARB_STICKY_OVF_EN
        v = '{2'b10, 16'd0, 16'd0, 4'd0, 16'h7FFF, 16'd1, 4'd0, 2'b10};
        run_vec(v);
        @(negedge clk);
        #1;
        check("sticky_set", {30'd0, sticky_ovf}, 32'd2);
        run_vec(v);
        sticky_clr = 2'b10;
        @(negedge clk);
        sticky_clr = 2'b00;
        #1;
        check("sticky_set_wins", {30'd0, sticky_ovf}, 32'd2);
        sticky_clr = 2'b10;
        @(negedge clk);
        sticky_clr = 2'b00;
        #1;
        check("sticky_clear", {30'd0, sticky_ovf}, 32'd0);
        @(negedge clk);
`endif

        check("sb_empty_end", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
